// File: rtl/bus_arb_pkg.sv
// Shared types and sizes for the bus arbiter master mux.
package bus_arb_pkg;

    localparam int unsigned N_MASTERS = 8;
    localparam int unsigned IDX_W     = 3;
    localparam int unsigned TMO_W     = 8;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT_RESP,
        DONE
    } arb_state_t;

endpackage

// File: rtl/bus_arb_onehot_enc.sv
// One-hot to binary index encoder; a zero input yields index 0.
module bus_arb_onehot_enc
    import bus_arb_pkg::*;
(
    input  logic [N_MASTERS-1:0] onehot,
    output logic [IDX_W-1:0]     idx_c
);

    always_comb begin
        idx_c = '0;
        for (int unsigned i = 0; i < N_MASTERS; i++) begin
            if (onehot[i]) begin
                idx_c = idx_c | IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/bus_arb_master_mux_8.sv
// Eight-requester master mux behind a round-robin arbiter, driving one shared slave port.
// Define ARB_TIMEOUT_EN to bound the read-response wait by TIMEOUT cycles.
module bus_arb_master_mux_8
    import bus_arb_pkg::*;
#(
    parameter int unsigned AW      = 32,
    parameter int unsigned DW      = 32,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [N_MASTERS-1:0]    m_valid,
    input  logic [N_MASTERS-1:0]    m_we,
    input  logic [N_MASTERS*AW-1:0] m_addr,
    input  logic [N_MASTERS*DW-1:0] m_wdata,
    output logic [N_MASTERS-1:0]    m_ready,
    output logic [DW-1:0]           m_rdata,
    output logic [N_MASTERS-1:0]    m_err,
    output logic [N_MASTERS-1:0]    arb_req,
    input  logic [N_MASTERS-1:0]    arb_gnt,
    output logic                    arb_ack,
    output logic                    s_valid,
    input  logic                    s_ready,
    output logic                    s_we,
    output logic [AW-1:0]           s_addr,
    output logic [DW-1:0]           s_wdata,
    input  logic                    s_rvalid,
    input  logic [DW-1:0]           s_rdata
);

    arb_state_t           state;
    arb_state_t           state_nxt;
    logic [N_MASTERS-1:0] owner;
    logic [IDX_W-1:0]     gnt_idx_c;
    logic                 tmo_hit_c;
    logic                 s_valid_nxt;
    logic                 arb_ack_nxt;
    logic [N_MASTERS-1:0] m_ready_nxt;

    bus_arb_onehot_enc u_enc (
        .onehot (arb_gnt),
        .idx_c  (gnt_idx_c)
    );

    // Once a transfer starts only the owner stays visible, so the grant cannot move.
    assign arb_req = (state == IDLE) ? m_valid : (m_valid & owner);

`ifdef ARB_TIMEOUT_EN
    logic [TMO_W-1:0]     tmo_cnt;
    logic [N_MASTERS-1:0] m_err_nxt;

    assign tmo_hit_c = (state == WAIT_RESP) && !s_rvalid && (tmo_cnt == TMO_W'(TIMEOUT));
    assign m_err_nxt = tmo_hit_c ? owner : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            tmo_cnt <= '0;
            m_err   <= '0;
        end else begin
            m_err <= m_err_nxt;
            if (state == ISSUE) begin
                tmo_cnt <= '0;
            end else if (state == WAIT_RESP) begin
                tmo_cnt <= tmo_cnt + TMO_W'(1);
            end
        end
    end
`else
    assign tmo_hit_c = 1'b0;
    assign m_err     = '0;
`endif

    // Next state plus next values of the registered handshake outputs.
    always_comb begin
        state_nxt   = state;
        s_valid_nxt = 1'b0;
        arb_ack_nxt = 1'b0;
        m_ready_nxt = '0;
        case (state)
            IDLE:      if (arb_gnt != '0) state_nxt = ISSUE;
            ISSUE:     if (s_ready) state_nxt = s_we ? DONE : WAIT_RESP;
            WAIT_RESP: if (s_rvalid || tmo_hit_c) state_nxt = DONE;
            DONE:      state_nxt = IDLE;
            default:   state_nxt = IDLE;
        endcase
        s_valid_nxt = (state_nxt == ISSUE);
        if (state_nxt == DONE) begin
            arb_ack_nxt = 1'b1;
            m_ready_nxt = owner;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            owner   <= '0;
            s_valid <= 1'b0;
            s_we    <= 1'b0;
            s_addr  <= '0;
            s_wdata <= '0;
            m_ready <= '0;
            m_rdata <= '0;
            arb_ack <= 1'b0;
        end else begin
            state   <= state_nxt;
            s_valid <= s_valid_nxt;
            m_ready <= m_ready_nxt;
            arb_ack <= arb_ack_nxt;
            if ((state == IDLE) && (arb_gnt != '0)) begin
                owner   <= arb_gnt;
                s_we    <= m_we[gnt_idx_c];
                s_addr  <= m_addr[32'(gnt_idx_c) * AW +: AW];
                s_wdata <= m_wdata[32'(gnt_idx_c) * DW +: DW];
            end
            if ((state == WAIT_RESP) && s_rvalid) begin
                m_rdata <= s_rdata;
            end else if (tmo_hit_c) begin
                m_rdata <= '0;
            end
        end
    end

endmodule

// File: tb/tb_bus_arb_master_mux_8.sv
// Directed bench for bus_arb_master_mux_8 with a round-robin arbiter model in the loop.
module tb_bus_arb_master_mux_8;

    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic [7:0]    m_valid;
    logic [7:0]    m_we;
    logic [8*AW-1:0] m_addr;
    logic [8*DW-1:0] m_wdata;
    logic [7:0]    m_ready;
    logic [DW-1:0] m_rdata;
    logic [7:0]    m_err;
    logic [7:0]    arb_req;
    logic [7:0]    arb_gnt;
    logic          arb_ack;
    logic          s_valid;
    logic          s_ready;
    logic          s_we;
    logic [AW-1:0] s_addr;
    logic [DW-1:0] s_wdata;
    logic          s_rvalid;
    logic [DW-1:0] s_rdata;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    bus_arb_master_mux_8 #(.AW(AW), .DW(DW), .TIMEOUT(4)) u_dut (
        .clk      (clk),
        .rst      (rst),
        .m_valid  (m_valid),
        .m_we     (m_we),
        .m_addr   (m_addr),
        .m_wdata  (m_wdata),
        .m_ready  (m_ready),
        .m_rdata  (m_rdata),
        .m_err    (m_err),
        .arb_req  (arb_req),
        .arb_gnt  (arb_gnt),
        .arb_ack  (arb_ack),
        .s_valid  (s_valid),
        .s_ready  (s_ready),
        .s_we     (s_we),
        .s_addr   (s_addr),
        .s_wdata  (s_wdata),
        .s_rvalid (s_rvalid),
        .s_rdata  (s_rdata)
    );

    // Round-robin arbiter model: priority starts after the last acked grant.
    logic [2:0] last;

    always_ff @(posedge clk) begin
        if (rst) begin
            last <= 3'd7;
        end else if (arb_ack && (arb_gnt != 8'h00)) begin
            for (int i = 0; i < 8; i++) begin
                if (arb_gnt[i]) last <= 3'(i);
            end
        end
    end

    always_comb begin
        arb_gnt = 8'h00;
        for (int k = 8; k >= 1; k--) begin
            if (arb_req[(int'(last) + k) % 8]) arb_gnt = 8'(1) << ((int'(last) + k) % 8);
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic set_req(input int i, input logic we, input logic [AW-1:0] addr,
                           input logic [DW-1:0] wdata);
        m_we[i]             = we;
        m_addr[i*AW +: AW]  = addr;
        m_wdata[i*DW +: DW] = wdata;
    endtask

    task automatic wait_ready(input int max_cyc, output int cyc, output logic [7:0] rdy);
        cyc = 0;
        rdy = 8'h00;
        while ((cyc < max_cyc) && (rdy == 8'h00)) begin
            @(negedge clk);
            cyc++;
            rdy = m_ready;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int         cyc;
        logic [7:0] rdy;

        rst = 1'b1; m_valid = '0; m_we = '0; m_addr = '0; m_wdata = '0;
        s_ready = 1'b0; s_rvalid = 1'b0; s_rdata = '0;
        repeat (2) @(negedge clk);
        check("rst_s_valid", s_valid, 0);
        check("rst_m_ready", m_ready, 0);
        check("rst_arb_ack", arb_ack, 0);
        check("rst_m_rdata", m_rdata, 0);
        check("rst_m_err",   m_err,   0);
        rst = 1'b0;
        @(negedge clk);

        // Single write from requester 2 with an immediately ready slave
        set_req(2, 1'b1, 32'h100, 32'hCAFE_0002);
        s_ready = 1'b1; m_valid = 8'h04;
        #1 check("w_arb_req", arb_req, 8'h04);
        @(negedge clk);
        check("w_s_valid", s_valid, 1);
        check("w_s_addr",  s_addr,  32'h100);
        check("w_s_we",    s_we,    1);
        check("w_s_wdata", s_wdata, 32'hCAFE_0002);
        check("w_ready_early", m_ready, 0);
        @(negedge clk);
        check("w_m_ready", m_ready, 8'h04);
        check("w_arb_ack", arb_ack, 1);
        check("w_m_err",   m_err,   0);
        m_valid = 8'h00;
        @(negedge clk);
        check("w_ready_pulse", m_ready, 0);
        check("w_ack_pulse",   arb_ack, 0);

        // Read from requester 0, response three cycles after accept
        set_req(0, 1'b0, 32'h200, 32'h0);
        m_valid = 8'h01;
        @(negedge clk);
        check("r_s_valid", s_valid, 1);
        check("r_s_we",    s_we,    0);
        check("r_s_addr",  s_addr,  32'h200);
        s_rvalid = 1'b1; s_rdata = 32'hBAD0_BAD0;
        @(negedge clk);
        s_rvalid = 1'b0;
        check("r_stray_rvalid", m_rdata, 0);
        check("r_s_valid_drop", s_valid, 0);
        @(negedge clk);
        check("r_wait", m_ready, 0);
        @(negedge clk);
        check("r_wait2", m_ready, 0);
        s_rvalid = 1'b1; s_rdata = 32'hDEAD_BEEF;
        @(negedge clk);
        s_rvalid = 1'b0;
        check("r_m_ready", m_ready, 8'h01);
        check("r_m_rdata", m_rdata, 32'hDEAD_BEEF);
        check("r_arb_ack", arb_ack, 1);
        m_valid = 8'h00;
        @(negedge clk);

        // Fairness from a fresh arbiter pointer, all requesters writing
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 8; i++) set_req(i, 1'b1, 32'h1000 + 32'(i * 4), 32'(i));
        m_valid = 8'hFF;
        for (int k = 0; k < 9; k++) begin
            wait_ready(8, cyc, rdy);
            check($sformatf("rr_order%0d", k), rdy, 8'(1) << (k % 8));
            check($sformatf("rr_lat%0d", k), cyc, (k == 0) ? 2 : 3);
        end
        m_valid = 8'h00;
        @(negedge clk);

        // Grant lock: requester 0 raised while requester 4 waits for a response
        set_req(4, 1'b0, 32'h400, 32'h0);
        set_req(0, 1'b1, 32'h500, 32'h55);
        m_valid = 8'h10;
        @(negedge clk);
        @(negedge clk);
        m_valid = 8'h11;
        #1 check("lk_req_wait", arb_req, 8'h10);
        @(negedge clk);
        check("lk_req_wait2", arb_req, 8'h10);
        s_rvalid = 1'b1; s_rdata = 32'h1234_5678;
        @(negedge clk);
        s_rvalid = 1'b0;
        check("lk_req_done", arb_req, 8'h10);
        check("lk_m_ready",  m_ready, 8'h10);
        check("lk_m_rdata",  m_rdata, 32'h1234_5678);
        m_valid = 8'h01;
        wait_ready(8, cyc, rdy);
        check("lk_next_owner", rdy, 8'h01);
        check("lk_next_lat",   cyc, 3);
        m_valid = 8'h00;
        @(negedge clk);

        // Reset while ISSUE is stalled by the slave
        set_req(3, 1'b1, 32'h300, 32'h3);
        s_ready = 1'b0; m_valid = 8'h08;
        @(negedge clk);
        check("rs_s_valid", s_valid, 1);
        rst = 1'b1;
        @(negedge clk);
        check("rs_s_valid_drop", s_valid, 0);
        check("rs_no_ready",     m_ready, 0);
        check("rs_no_ack",       arb_ack, 0);
        rst = 1'b0; s_ready = 1'b1; m_valid = 8'h09;
        wait_ready(8, cyc, rdy);
        check("rs_first_owner", rdy, 8'h01);
        check("rs_first_lat",   cyc, 2);
        wait_ready(8, cyc, rdy);
        check("rs_second_owner", rdy, 8'h08);
        m_valid = 8'h00;
        @(negedge clk);

`ifdef ARB_TIMEOUT_EN
        // Read with no response is forced complete after TIMEOUT
        set_req(5, 1'b0, 32'h600, 32'h0);
        m_valid = 8'h20;
        wait_ready(12, cyc, rdy);
        check("to_m_ready", rdy,     8'h20);
        check("to_lat",     cyc,     7);
        check("to_m_err",   m_err,   8'h20);
        check("to_m_rdata", m_rdata, 0);
        m_valid = 8'h00;
        @(negedge clk);
        check("to_err_pulse", m_err, 0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
